// File: rtl/ll_rx_stb_align.sv
// ll_rx_stb_align
//
// Receive-side alignment tracker for the auto-sync link. The transmitter
// sends a strobe userbit once every stb_interval cycles. It also sends a
// persistent marker pattern on the marker userbits. This block:
//   - searches for the first strobe,
//   - tracks the strobe period until LOCK_COUNT good strobes arrive in a row,
//   - holds lock until UNLOCK_COUNT consecutive strobe mismatch events occur,
//   - counts strobe and marker errors while locked.
//
// Ports
//   clk_wr                 sole clock
//   rst_wr_n               asynchronous active-low reset
//   rx_online              enables alignment; low forces IDLE
//   stb_interval[7:0]      strobe period in cycles (0 and 1 behave as 2)
//   rx_stb_userbit         received strobe bit
//   rx_mrk_userbit[MW-1:0] received marker bits
//   mrk_expect[MW-1:0]     expected marker pattern
//   clr_err                clears both error counters next cycle
//   rx_align_done          registered lock indication
//   rx_align_state[1:0]    registered FSM state (IDLE/SEARCH/TRACK/LOCKED)
//   stb_err_cnt[15:0]      saturating strobe mismatch count
//   mrk_err_cnt[15:0]      saturating marker mismatch count
//   rx_align_debug_status  registered debug word:
//                          {state, rx_online, done, good[3:0], miss[3:0],
//                           4'h0, stb_err[7:0], mrk_err[7:0]}
module ll_rx_stb_align #(
    parameter int MARKER_WIDTH = 2,
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3
) (
    input  logic                    clk_wr,
    input  logic                    rst_wr_n,
    input  logic                    rx_online,
    input  logic [7:0]              stb_interval,
    input  logic                    rx_stb_userbit,
    input  logic [MARKER_WIDTH-1:0] rx_mrk_userbit,
    input  logic [MARKER_WIDTH-1:0] mrk_expect,
    input  logic                    clr_err,
    output logic                    rx_align_done,
    output logic [1:0]              rx_align_state,
    output logic [15:0]             stb_err_cnt,
    output logic [15:0]             mrk_err_cnt,
    output logic [31:0]             rx_align_debug_status
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_CNT_L   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_CNT_L = 4'(UNLOCK_COUNT);

    state_t      state_q, state_d;
    logic [7:0]  phase_cnt_q, phase_cnt_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic [3:0]  miss_cnt_q, miss_cnt_d;
    logic [15:0] stb_err_q, stb_err_d;
    logic [15:0] mrk_err_q, mrk_err_d;
    logic        done_q, done_d;
    logic [31:0] debug_q, debug_d;

    logic [7:0]  interval_eff;
    logic        at_expected;
    logic [3:0]  good_inc;
    logic [3:0]  miss_inc;

    // Intervals below 2 cannot be distinguished from a continuous strobe,
    // so they are clamped to the shortest usable period.
    always_comb begin
        interval_eff = (stb_interval < 8'd2) ? 8'd2 : stb_interval;
        at_expected  = (phase_cnt_q == interval_eff);
        good_inc     = good_cnt_q + 4'd1;
        miss_inc     = (miss_cnt_q == 4'hF) ? 4'hF : miss_cnt_q + 4'd1;
    end

    // Next-state and counter logic.
    // In LOCKED the phase grid keeps running from the last lock point.
    // Strays and misses are counted there, never used to re-anchor.
    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        good_cnt_d  = good_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        stb_err_d   = stb_err_q;
        mrk_err_d   = mrk_err_q;

        if (!rx_online) begin
            state_d     = ST_IDLE;
            phase_cnt_d = 8'd0;
            good_cnt_d  = 4'd0;
            miss_cnt_d  = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_SEARCH;
                    phase_cnt_d = 8'd0;
                    good_cnt_d  = 4'd0;
                    miss_cnt_d  = 4'd0;
                end

                ST_SEARCH: begin
                    if (rx_stb_userbit) begin
                        state_d     = ST_TRACK;
                        phase_cnt_d = 8'd1;
                        good_cnt_d  = 4'd1;
                    end else begin
                        phase_cnt_d = 8'd0;
                        good_cnt_d  = 4'd0;
                    end
                end

                ST_TRACK: begin
                    if (at_expected) begin
                        if (rx_stb_userbit) begin
                            phase_cnt_d = 8'd1;
                            good_cnt_d  = good_inc;
                            if (good_inc >= LOCK_CNT_L) begin
                                state_d    = ST_LOCKED;
                                miss_cnt_d = 4'd0;
                            end
                        end else begin
                            state_d     = ST_SEARCH;
                            phase_cnt_d = 8'd0;
                            good_cnt_d  = 4'd0;
                        end
                    end else if (rx_stb_userbit) begin
                        // An early strobe is treated as the new reference.
                        phase_cnt_d = 8'd1;
                        good_cnt_d  = 4'd1;
                    end else begin
                        phase_cnt_d = phase_cnt_q + 8'd1;
                    end
                end

                ST_LOCKED: begin
                    phase_cnt_d = at_expected ? 8'd1 : phase_cnt_q + 8'd1;

                    // Missing at the expected slot or present anywhere else.
                    if (at_expected ^ rx_stb_userbit) begin
                        if (stb_err_q != 16'hFFFF) begin
                            stb_err_d = stb_err_q + 16'd1;
                        end
                        if (miss_inc >= UNLOCK_CNT_L) begin
                            state_d     = ST_SEARCH;
                            phase_cnt_d = 8'd0;
                            good_cnt_d  = 4'd0;
                            miss_cnt_d  = 4'd0;
                        end else begin
                            miss_cnt_d = miss_inc;
                        end
                    end else if (at_expected) begin
                        miss_cnt_d = 4'd0;
                    end

                    if ((rx_mrk_userbit != mrk_expect) && (mrk_err_q != 16'hFFFF)) begin
                        mrk_err_d = mrk_err_q + 16'd1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Clearing wins over any increment computed above.
        if (clr_err) begin
            stb_err_d = 16'd0;
            mrk_err_d = 16'd0;
        end
    end

    // The lock flag and debug word are built from next-state values.
    // They update on the same edge as the state they describe.
    always_comb begin
        done_d  = (state_d == ST_LOCKED);
        debug_d = {state_d, rx_online, done_d, good_cnt_d, miss_cnt_d,
                   4'h0, stb_err_d[7:0], mrk_err_d[7:0]};
    end

    // State and counter registers.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state_q     <= ST_IDLE;
            phase_cnt_q <= 8'd0;
            good_cnt_q  <= 4'd0;
            miss_cnt_q  <= 4'd0;
            stb_err_q   <= 16'd0;
            mrk_err_q   <= 16'd0;
            done_q      <= 1'b0;
            debug_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            good_cnt_q  <= good_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            stb_err_q   <= stb_err_d;
            mrk_err_q   <= mrk_err_d;
            done_q      <= done_d;
            debug_q     <= debug_d;
        end
    end

    always_comb begin
        rx_align_done         = done_q;
        rx_align_state        = state_q;
        stb_err_cnt           = stb_err_q;
        mrk_err_cnt           = mrk_err_q;
        rx_align_debug_status = debug_q;
    end

endmodule
